// File: rtl/seg_scan_multi.sv
// Multiplexed seven-segment driver: latches packed hex digits, scans them one slot at a time
// with a blank window at the start of each slot, optional leading-zero suppression and per-digit dp.
module seg_scan_multi #(
  parameter int DIGITS       = 4,
  parameter int DIV          = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   DATA,
  input  logic [DIGITS-1:0]     DP_EN,
  input  logic                  BLANK_LZ,
  output logic [DIGITS-1:0]     SCAN_OUT,
  output logic [7:0]            SEG_OUT
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic             INV      = (ACTIVE_LOW != 0);

  logic [4*DIGITS-1:0] r_data;
  logic [DIGITS-1:0]   r_dp;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [DIGITS-1:0]   r_scan;
  logic [7:0]          r_seg;

  logic [3:0]          w_nib [DIGITS];
  logic [DIGITS-1:0]   w_upper_zero;
  logic                w_in_blank;
  logic                w_lz_blank;
  logic [3:0]          w_nib_sel;
  logic [DIGITS-1:0]   w_scan_next;
  logic [7:0]          w_seg_next;

  function automatic logic [6:0] f_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // w_upper_zero[i]: nibbles i..DIGITS-1 are all zero, i.e. digit i is a leading zero
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
      assign w_nib[gi]        = r_data[4*gi +: 4];
      assign w_upper_zero[gi] = (r_data[4*DIGITS-1:4*gi] == '0);
    end
  endgenerate

  generate
    if (BLANK_CYCLES > 0) begin : g_blank
      localparam logic [CNT_W-1:0] BLANK_TH = CNT_W'(BLANK_CYCLES);
      assign w_in_blank = (r_cnt < BLANK_TH);
    end else begin : g_noblank
      assign w_in_blank = 1'b0;
    end
  endgenerate

  always_comb begin
    w_nib_sel   = w_nib[r_idx];
    w_lz_blank  = BLANK_LZ && (r_idx != '0) && w_upper_zero[r_idx];
    w_scan_next = '0;
    w_seg_next  = '0;
    if (!w_in_blank) begin
      w_scan_next = DIGITS'(1) << r_idx;
      w_seg_next  = {r_dp[r_idx], w_lz_blank ? 7'h00 : f_decode(w_nib_sel)};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_data <= '0;
      r_dp   <= '0;
      r_cnt  <= '0;
      r_idx  <= '0;
      r_scan <= {DIGITS{INV}};
      r_seg  <= {8{INV}};
    end else begin
      if (LOAD) begin
        r_data <= DATA;
        r_dp   <= DP_EN;
      end
      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Polarity is applied only at the register so both board types see identical timing
      r_scan <= w_scan_next ^ {DIGITS{INV}};
      r_seg  <= w_seg_next ^ {8{INV}};
    end
  end

  assign SCAN_OUT = r_scan;
  assign SEG_OUT  = r_seg;

endmodule

// File: tb/tb_seg_scan_multi.sv
// Directed bench for seg_scan_multi (DIGITS=4, DIV=8, BLANK_CYCLES=2); an active-low
// twin shares all inputs and is held to the bitwise complement of the expected outputs.
module tb_seg_scan_multi;

  typedef struct packed {
    logic [15:0]     data;
    logic [3:0]      dp;
    logic            blz;
    logic [3:0][7:0] seg;   // expected SEG_OUT per digit, seg[0] = digit 0
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        LOAD = 1'b0;
  logic [15:0] DATA = '0;
  logic [3:0]  DP_EN = '0;
  logic        BLANK_LZ = 1'b0;
  logic [3:0]  scan, scan_al;
  logic [7:0]  seg, seg_al;

  int checks = 0;
  int errors = 0;
  int k = 0;   // posedges since reset release; state during cycle k has cnt=k%8

  vec_t vecs[9];

  seg_scan_multi #(.DIGITS(4), .DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW(0)) dut (
    .clock(clock), .reset(reset), .LOAD(LOAD), .DATA(DATA), .DP_EN(DP_EN),
    .BLANK_LZ(BLANK_LZ), .SCAN_OUT(scan), .SEG_OUT(seg)
  );

  seg_scan_multi #(.DIGITS(4), .DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1)) dut_al (
    .clock(clock), .reset(reset), .LOAD(LOAD), .DATA(DATA), .DP_EN(DP_EN),
    .BLANK_LZ(BLANK_LZ), .SCAN_OUT(scan_al), .SEG_OUT(seg_al)
  );

  always #5 clock = ~clock;

  always @(posedge clock) k <= reset ? 0 : k + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got %h expected %h", name, k, act, exp);
    end
  endtask

  // Outputs seen after edge k were computed from the state of cycle k-1
  task automatic check_cycle(input logic [31:0] segs, input string tag);
    int s;
    int cnt;
    int idx;
    logic [3:0] es;
    logic [7:0] eg;
    s   = k - 1;
    cnt = s % 8;
    idx = (s / 8) % 4;
    if (cnt < 2) begin
      es = 4'h0;
      eg = 8'h00;
    end else begin
      es = 4'(1 << idx);
      eg = segs[idx*8 +: 8];
    end
    chk({tag, "_scan"}, {28'h0, scan}, {28'h0, es});
    chk({tag, "_seg"}, {24'h0, seg}, {24'h0, eg});
    chk({tag, "_al_scan"}, {28'h0, scan_al}, {28'h0, ~es});
    chk({tag, "_al_seg"}, {24'h0, seg_al}, {24'h0, ~eg});
  endtask

  task automatic wait_k_mod(input int m);
    int n;
    n = 0;
    @(negedge clock);
    while ((k % 32) != m && n < 40) begin
      @(negedge clock);
      n++;
    end
    if ((k % 32) != m) chk("align_timeout", 32'(k % 32), 32'(m));
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, 1'b0, 32'h065B4F66};
    vecs[1] = '{16'h0050, 4'b0000, 1'b1, 32'h00006D3F};
    vecs[2] = '{16'h0050, 4'b0000, 1'b0, 32'h3F3F6D3F};
    vecs[3] = '{16'h0000, 4'b0100, 1'b1, 32'h0080003F};
    vecs[4] = '{16'h000F, 4'b0000, 1'b0, 32'h3F3F3F71};
    vecs[5] = '{16'h8A0C, 4'b1001, 1'b1, 32'hFF773FB9};
    vecs[6] = '{16'h0E00, 4'b0000, 1'b1, 32'h00793F3F};
    vecs[7] = '{16'hB7D6, 4'b0000, 1'b0, 32'h7C075E7D};
    vecs[8] = '{16'h9FE8, 4'b0010, 1'b0, 32'h6F71F97F};

    // Reset state, then idle frame start with cleared data
    repeat (2) @(negedge clock);
    chk("rst_scan", {28'h0, scan}, 32'h0);
    chk("rst_seg", {24'h0, seg}, 32'h0);
    chk("rst_al_scan", {28'h0, scan_al}, 32'hF);
    chk("rst_al_seg", {24'h0, seg_al}, 32'hFF);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check_cycle(32'h3F3F3F3F, "idle");
    end
    $display("idle slot 0 after reset checked");

    // Table-driven: load each vector, then check a whole frame cycle by cycle
    for (int v = 0; v < 9; v++) begin
      @(negedge clock);
      DATA     = vecs[v].data;
      DP_EN    = vecs[v].dp;
      BLANK_LZ = vecs[v].blz;
      LOAD     = 1'b1;
      @(negedge clock);
      LOAD = 1'b0;
      wait_k_mod(0);
      for (int c = 0; c < 32; c++) begin
        @(negedge clock);
        check_cycle(vecs[v].seg, $sformatf("v%0d", v));
      end
      $display("vec %0d DATA=%h DP_EN=%b BLANK_LZ=%b frame checked", v, vecs[v].data,
               vecs[v].dp, vecs[v].blz);
    end

    // Asynchronous reset in the middle of digit 2's lit window
    BLANK_LZ = 1'b0;
    wait_k_mod(21);
    chk("pre_rst_scan", {28'h0, scan}, 32'h4);
    reset = 1'b1;
    #1;
    chk("async_rst_scan", {28'h0, scan}, 32'h0);
    chk("async_rst_seg", {24'h0, seg}, 32'h0);
    chk("async_rst_al_scan", {28'h0, scan_al}, 32'hF);
    chk("async_rst_al_seg", {24'h0, seg_al}, 32'hFF);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check_cycle(32'h3F3F3F3F, "post_rst");
    end
    $display("mid-slot reset: data cleared, scan restarted at digit 0");

    // LOAD on the last cycle of slot 0: slot 1 must already show the new nibble
    wait_k_mod(7);
    DATA  = 16'h4321;
    DP_EN = 4'b0000;
    LOAD  = 1'b1;
    @(negedge clock);
    LOAD = 1'b0;
    check_cycle(32'h3F3F3F3F, "bnd_old");
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check_cycle(32'h664F5B06, "bnd_new");
    end
    $display("LOAD at slot boundary: new nibble shown in next slot");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
